// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB slave-side bus bundle for the simulink2ppc snapshot register.
// Signal names and big-endian bit numbering follow the OPB bus itself.
interface opb_register_simulink2ppc_snap_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PPC snapshot register: captures user words into a holding register with a
// full flag and a saturating overflow counter, exposed as DATA/STATUS/CONTROL on OPB.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned C_OVERWRITE  = 1,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                                  OPB_Clk,
    input  logic                                  OPB_Rst,
    opb_register_simulink2ppc_snap_if.slave       opb,
    input  logic [31:0]                           user_data_in,
    input  logic                                  user_valid,
    output logic                                  user_full
);

    typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

    localparam logic [5:0] RegData    = 6'd0;
    localparam logic [5:0] RegStatus  = 6'd1;
    localparam logic [5:0] RegControl = 6'd2;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        full_q, full_d;
    logic [15:0] ovf_q, ovf_d;
    logic        ack_q, ack_d;
    logic [0:31] rdata_q, rdata_d;

    logic        hit;
    logic        data_rd;
    logic        ovf_clr;
    logic        ovf_inc;
    logic [5:0]  reg_sel;
    logic [32:0] diff_lo, diff_hi;
    logic        unused_ok;

    // Window check by borrow of 33-bit differences, so a zero base needs no special case
    assign diff_lo = {1'b0, opb.OPB_ABus} - {1'b0, C_BASEADDR};
    assign diff_hi = {1'b0, C_HIGHADDR} - {1'b0, opb.OPB_ABus};
    assign hit     = opb.OPB_select && !diff_lo[32] && !diff_hi[32];
    assign reg_sel = opb.OPB_ABus[24:29];

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hit) state_d = StAck;
            StAck:   state_d = StWait;
            StWait:  if (!opb.OPB_select) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are registered, so the ack and its side effects land on the same edge
    always_comb begin
        ack_d   = 1'b0;
        rdata_d = '0;
        data_rd = 1'b0;
        ovf_clr = 1'b0;
        if (state_q == StAck) begin
            ack_d = 1'b1;
            if (opb.OPB_RNW) begin
                case (reg_sel)
                    RegData: begin
                        rdata_d = hold_q;
                        data_rd = 1'b1;
                    end
                    RegStatus: rdata_d = {ovf_q, 15'd0, full_q};
                    default:   rdata_d = '0;
                endcase
            end else if (reg_sel == RegControl && opb.OPB_BE[3] && opb.OPB_DBus[31]) begin
                ovf_clr = 1'b1;
            end
        end
    end

    // A DATA read frees the slot in the same cycle, so a coincident word is a clean load
    always_comb begin
        hold_d  = hold_q;
        full_d  = full_q;
        ovf_inc = 1'b0;
        if (user_valid) begin
            if (!full_q || data_rd) begin
                hold_d = user_data_in;
                full_d = 1'b1;
            end else begin
                ovf_inc = 1'b1;
                if (C_OVERWRITE != 0) hold_d = user_data_in;
            end
        end else if (data_rd) begin
            full_d = 1'b0;
        end

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = '0;
        end else if (ovf_inc && ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            hold_q  <= '0;
            full_q  <= 1'b0;
            ovf_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            hold_q  <= hold_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign opb.Sl_xferAck = ack_q;
    assign opb.Sl_DBus    = rdata_q;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;
    assign user_full      = full_q;

    assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], opb.OPB_DBus[0:30],
                         opb.OPB_ABus[30:31], diff_lo[31:0], diff_hi[31:0]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Scoreboard bench: two DUTs (overwrite on/off) share one OPB master; each transfer
// queues its expected read data and per-DUT monitors check every acknowledge.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] Base  = 32'h8000_0000;
    localparam logic [31:0] High  = 32'h8000_00FF;
    localparam logic [31:0] AData = Base + 32'h0;
    localparam logic [31:0] AStat = Base + 32'h4;
    localparam logic [31:0] ACtrl = Base + 32'h8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] user_data;
    logic        user_valid;
    logic        user_full1, user_full2;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic        last_full;
    logic [0:31] last_rdata;
    int          stray;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_snap_if bus1 ();
    opb_register_simulink2ppc_snap_if bus2 ();

    assign bus2.OPB_ABus    = bus1.OPB_ABus;
    assign bus2.OPB_BE      = bus1.OPB_BE;
    assign bus2.OPB_DBus    = bus1.OPB_DBus;
    assign bus2.OPB_RNW     = bus1.OPB_RNW;
    assign bus2.OPB_select  = bus1.OPB_select;
    assign bus2.OPB_seqAddr = bus1.OPB_seqAddr;

    opb_register_simulink2ppc_snap #(
        .C_BASEADDR(Base), .C_HIGHADDR(High), .C_OVERWRITE(1)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .opb(bus1),
        .user_data_in(user_data), .user_valid(user_valid), .user_full(user_full1)
    );

    opb_register_simulink2ppc_snap #(
        .C_BASEADDR(Base), .C_HIGHADDR(High), .C_OVERWRITE(0)
    ) dut_keep (
        .OPB_Clk(clk), .OPB_Rst(rst), .opb(bus2),
        .user_data_in(user_data), .user_valid(user_valid), .user_full(user_full2)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (bus1.Sl_xferAck) begin
            last_full  = user_full1;
            last_rdata = bus1.Sl_DBus;
            chk("tied_zero1", {29'd0, bus1.Sl_errAck, bus1.Sl_retry, bus1.Sl_toutSup}, 32'd0);
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack1: got ack with data %h, expected no ack",
                         bus1.Sl_DBus);
            end else begin
                chk("rdata_ovw", bus1.Sl_DBus, q1.pop_front());
            end
        end else if (bus1.OPB_select) begin
            chk("idle_dbus1", bus1.Sl_DBus, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (bus2.Sl_xferAck) begin
            if (q2.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack2: got ack with data %h, expected no ack",
                         bus2.Sl_DBus);
            end else begin
                chk("rdata_keep", bus2.Sl_DBus, q2.pop_front());
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] e1, input logic [31:0] e2,
                        input logic cv, input logic [31:0] cw);
        logic got;
        got = 1'b0;
        q1.push_back(e1);
        q2.push_back(e2);
        @(posedge clk);
        #1;
        bus1.OPB_ABus   = addr;
        bus1.OPB_RNW    = rnw;
        bus1.OPB_DBus   = wdata;
        bus1.OPB_BE     = be;
        bus1.OPB_select = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus1.Sl_xferAck) begin
                got = 1'b1;
                chk("ack_latency", i, 32'd2);
            end else if (cv && i == 0) begin
                @(posedge clk);
                #1;
                user_valid = 1'b1;
                user_data  = cw;
            end else if (cv && i == 1) begin
                @(posedge clk);
                #1;
                user_valid = 1'b0;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack in 20 cycles at %h, expected an ack", addr);
        end
        @(posedge clk);
        #1;
        bus1.OPB_select = 1'b0;
        bus1.OPB_DBus   = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] w);
        @(posedge clk);
        #1;
        user_valid = 1'b1;
        user_data  = w;
        @(posedge clk);
        #1;
        user_valid = 1'b0;
    endtask

    task automatic no_ack_window(input logic [31:0] addr);
        stray = 0;
        @(posedge clk);
        #1;
        bus1.OPB_ABus   = addr;
        bus1.OPB_RNW    = 1'b1;
        bus1.OPB_select = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus1.Sl_xferAck || bus2.Sl_xferAck) stray++;
        end
        chk("out_of_window_acks", stray, 32'd0);
        @(posedge clk);
        #1;
        bus1.OPB_select = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        user_valid       = 1'b0;
        user_data        = '0;
        bus1.OPB_ABus    = '0;
        bus1.OPB_BE      = '0;
        bus1.OPB_DBus    = '0;
        bus1.OPB_RNW     = 1'b0;
        bus1.OPB_select  = 1'b0;
        bus1.OPB_seqAddr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_full", {30'd0, user_full2, user_full1}, 32'd0);
        chk("reset_ack", {30'd0, bus2.Sl_xferAck, bus1.Sl_xferAck}, 32'd0);
        chk("reset_dbus", bus1.Sl_DBus, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        xfer(AStat, 1'b1, 0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);

        // Single word round trip
        pulse(32'hDEAD_BEEF);
        @(negedge clk);
        chk("full_after_capture", {31'd0, user_full1}, 32'd1);
        xfer(AStat, 1'b1, 0, 4'hF, 32'h0000_0001, 32'h0000_0001, 1'b0, 0);
        xfer(AData, 1'b1, 0, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
        chk("full_in_data_ack", {31'd0, last_full}, 32'd0);
        chk("dbus_top_nibble", {28'd0, last_rdata[0:3]}, 32'hD);
        xfer(AStat, 1'b1, 0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);

        // Overrun: overwrite keeps the newest word, no-overwrite the oldest
        pulse(32'h11);
        pulse(32'h22);
        pulse(32'h33);
        xfer(AStat, 1'b1, 0, 4'hF, 32'h0002_0001, 32'h0002_0001, 1'b0, 0);
        xfer(AData, 1'b1, 0, 4'hF, 32'h0000_0033, 32'h0000_0011, 1'b0, 0);

        // New word in the DATA read ack cycle
        pulse(32'h44);
        xfer(AData, 1'b1, 0, 4'hF, 32'h0000_0044, 32'h0000_0044, 1'b1, 32'h55);
        chk("full_kept_on_coincide", {31'd0, last_full}, 32'd1);
        xfer(AStat, 1'b1, 0, 4'hF, 32'h0002_0001, 32'h0002_0001, 1'b0, 0);
        xfer(AData, 1'b1, 0, 4'hF, 32'h0000_0055, 32'h0000_0055, 1'b0, 0);

        // Unmapped offsets and out-of-window addresses
        xfer(Base + 32'h10, 1'b1, 0, 4'hF, 32'h0, 32'h0, 1'b0, 0);
        xfer(Base + 32'h0C, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, 1'b0, 0);
        xfer(AStat, 1'b1, 0, 4'hF, 32'h0002_0000, 32'h0002_0000, 1'b0, 0);
        no_ack_window(High + 32'h1);
        no_ack_window(Base - 32'h4);

        // Saturation, byte-enable gating, clear winning over a coincident increment
        @(posedge clk);
        #1;
        user_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            user_data = i;
            @(posedge clk);
            #1;
        end
        user_valid = 1'b0;
        xfer(AStat, 1'b1, 0, 4'hF, 32'hFFFF_0001, 32'hFFFF_0001, 1'b0, 0);
        xfer(ACtrl, 1'b0, 32'h1, 4'b1110, 32'h0, 32'h0, 1'b0, 0);
        xfer(AStat, 1'b1, 0, 4'hF, 32'hFFFF_0001, 32'hFFFF_0001, 1'b0, 0);
        xfer(ACtrl, 1'b0, 32'h1, 4'b0001, 32'h0, 32'h0, 1'b1, 32'h66);
        xfer(AStat, 1'b1, 0, 4'hF, 32'h0000_0001, 32'h0000_0001, 1'b0, 0);

        // Reset in the ACK state: no ack, state cleared, held select retries
        q1.push_back(32'h0);
        q2.push_back(32'h0);
        @(posedge clk);
        #1;
        bus1.OPB_ABus   = AStat;
        bus1.OPB_RNW    = 1'b1;
        bus1.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ack_during_reset", {31'd0, bus1.Sl_xferAck}, 32'd0);
        chk("full_after_reset", {31'd0, user_full1}, 32'd0);
        stray = 0;
        for (int i = 0; i < 10 && stray == 0; i++) begin
            @(negedge clk);
            if (bus1.Sl_xferAck) stray = 1;
        end
        chk("retry_acked", stray, 32'd1);
        @(posedge clk);
        #1;
        bus1.OPB_select = 1'b0;
        @(posedge clk);
        #1;
        xfer(AData, 1'b1, 0, 4'hF, 32'h0, 32'h0, 1'b0, 0);

        repeat (3) @(posedge clk);
        chk("queue_ovw_drained", q1.size(), 32'd0);
        chk("queue_keep_drained", q2.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
